// File: rtl/bg_scan_pkg.sv
// Shared constants and types for the background raster scanner.
package bg_scan_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COLOR_W  = 12;
    localparam int ROM_W    = 7;
    localparam int CNT_W    = 10;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [ROM_W-1:0]   rom_coord_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // Per-pixel decode carried from the fetch stage to the output stage.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } pix_ctl_t;

    // Downscale a screen coordinate and add scroll; 7-bit truncation tiles the ROM.
    function automatic rom_coord_t scale_scroll(input cnt_t c, input int unsigned sh,
                                                input rom_coord_t s);
        cnt_t sc;
        sc = c >> sh;
        return sc[ROM_W-1:0] + s;
    endfunction

endpackage

// File: rtl/bg_scanner_vga_timing.sv
// Pixel divider plus horizontal/vertical raster counters with active and sync decode.
module vga_timing
    import bg_scan_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_F      = H_FP,
    parameter int H_S      = H_SYNC,
    parameter int H_B      = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_F      = V_FP,
    parameter int V_S      = V_SYNC,
    parameter int V_B      = V_BP
) (
    input  logic     clk,
    input  logic     rst_n,
    output logic     tick,
    output cnt_t     h_cnt,
    output cnt_t     v_cnt,
    output logic     frame_wrap,
    output logic     line_act,
    output pix_ctl_t pix_ctl
);

    localparam int H_TOT = H_ACT + H_F + H_S + H_B;
    localparam int V_TOT = V_ACT + V_F + V_S + V_B;
    localparam int DIV_W = $clog2(DIV);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    cnt_t             h_cnt_q, h_cnt_d;
    cnt_t             v_cnt_q, v_cnt_d;
    logic             h_wrap, v_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        h_wrap    = (h_cnt_q == cnt_t'(H_TOT - 1));
        v_wrap    = (v_cnt_q == cnt_t'(V_TOT - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_comb begin
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        frame_wrap  = tick && h_wrap && v_wrap;
        line_act    = (v_cnt_q < cnt_t'(V_ACT));
        pix_ctl.act = (h_cnt_q < cnt_t'(H_ACT)) && line_act;
        pix_ctl.hs  = (h_cnt_q >= cnt_t'(H_ACT + H_F)) &&
                      (h_cnt_q <  cnt_t'(H_ACT + H_F + H_S));
        pix_ctl.vs  = (v_cnt_q >= cnt_t'(V_ACT + V_F)) &&
                      (v_cnt_q <  cnt_t'(V_ACT + V_F + V_S));
    end

endmodule

// File: rtl/bg_scanner.sv
// Background raster scanner: scrolled/scaled ROM addressing and aligned RGB + sync out.
module bg_scanner
    import bg_scan_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = bg_scan_pkg::H_ACTIVE,
    parameter int H_FP        = bg_scan_pkg::H_FP,
    parameter int H_SYNC      = bg_scan_pkg::H_SYNC,
    parameter int H_BP        = bg_scan_pkg::H_BP,
    parameter int V_ACTIVE    = bg_scan_pkg::V_ACTIVE,
    parameter int V_FP        = bg_scan_pkg::V_FP,
    parameter int V_SYNC      = bg_scan_pkg::V_SYNC,
    parameter int V_BP        = bg_scan_pkg::V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ROM_W-1:0]   scroll_x,
    input  logic [ROM_W-1:0]   scroll_y,
    output logic               rom_en,
    output logic [ROM_W-1:0]   rom_x,
    output logic [ROM_W-1:0]   rom_y,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               frame_start
);

    // The ROM needs two clocks, which must fit inside one pixel period.
    if (DIV < 3) begin : g_bad_div
        $error("bg_scanner: DIV must be >= 3");
    end

    logic     tick, frame_wrap, line_act;
    cnt_t     h_cnt, v_cnt;
    pix_ctl_t pix_ctl;

    vga_timing #(
        .DIV   (DIV),
        .H_ACT (H_ACTIVE), .H_F (H_FP), .H_S (H_SYNC), .H_B (H_BP),
        .V_ACT (V_ACTIVE), .V_F (V_FP), .V_S (V_SYNC), .V_B (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .frame_wrap (frame_wrap),
        .line_act   (line_act),
        .pix_ctl    (pix_ctl)
    );

    rom_coord_t scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
    rom_coord_t rom_x_q, rom_x_d, rom_y_q, rom_y_d;
    logic       rom_en_q, rom_en_d;
    pix_ctl_t   ctl_q, ctl_d;
    color_t     rgb_q, rgb_d;
    logic       hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic       frame_start_q, frame_start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_x_q    <= '0;
            scroll_y_q    <= '0;
            rom_x_q       <= '0;
            rom_y_q       <= '0;
            rom_en_q      <= 1'b0;
            ctl_q         <= '0;
            rgb_q         <= '0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            scroll_x_q    <= scroll_x_d;
            scroll_y_q    <= scroll_y_d;
            rom_x_q       <= rom_x_d;
            rom_y_q       <= rom_y_d;
            rom_en_q      <= rom_en_d;
            ctl_q         <= ctl_d;
            rgb_q         <= rgb_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        // Address math sees the freshly latched scroll on the boundary tick.
        scroll_x_d    = frame_wrap ? scroll_x : scroll_x_q;
        scroll_y_d    = frame_wrap ? scroll_y : scroll_y_q;
        frame_start_d = frame_wrap;
        rom_x_d       = rom_x_q;
        rom_y_d       = rom_y_q;
        rom_en_d      = rom_en_q;
        ctl_d         = ctl_q;
        rgb_d         = rgb_q;
        hsync_n_d     = hsync_n_q;
        vsync_n_d     = vsync_n_q;
        if (tick) begin
            rom_x_d   = scale_scroll(h_cnt, SCALE_SHIFT, scroll_x_d);
            rom_y_d   = scale_scroll(v_cnt, SCALE_SHIFT, scroll_y_d);
            rom_en_d  = line_act;
            ctl_d     = pix_ctl;
            rgb_d     = ctl_q.act ? rom_color : '0;
            hsync_n_d = ~ctl_q.hs;
            vsync_n_d = ~ctl_q.vs;
        end
    end

    always_comb begin
        rom_x       = rom_x_q;
        rom_y       = rom_y_q;
        rom_en      = rom_en_q;
        rgb         = rgb_q;
        hsync_n     = hsync_n_q;
        vsync_n     = vsync_n_q;
        frame_start = frame_start_q;
    end

endmodule
